simon_stream_collector: RTL and testbench
=========================================

# simon_stream_collector

Deserializing output stage placed directly downstream of the bit-serial Simon cipher core. It samples the core's serial ciphertext/key stream (`cipher_out` qualified by `valid`), packs it into bytes, buffers complete bytes in a small first-word-fall-through FIFO and presents them on a valid/ready byte interface. It also reports block completion, truncated streams and FIFO overflow, so a parallel host or a UART/SPI bridge can read whole blocks without tracking serial timing.

## Interface
- `BLOCK_BITS`, 64: bits per cipher block; must be a multiple of 8 and at least 8.
- `FIFO_DEPTH`, 4: byte FIFO depth; must be a power of 2 and at least 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `ser_in`  input  1  serial data from the cipher core's `cipher_out`.
- `ser_valid`  input  1  from the cipher core's `valid`; `ser_in` is sampled on every edge where this is 1.
- `err_clr`  input  1  one-cycle pulse that clears the `overflow` and `frame_err` sticky flags.
- `byte_out`  output  8  FIFO head byte; meaningful only while `byte_valid`=1.
- `byte_valid`  output  1  FIFO not empty.
- `byte_ready`  input  1  consumer accept; a pop occurs on an edge where `byte_valid` and `byte_ready` are both 1.
- `block_done`  output  1  one-cycle pulse after the last bit of a block is sampled.
- `overflow`  output  1  sticky: a completed byte was dropped because the FIFO was full.
- `frame_err`  output  1  sticky: `ser_valid` fell in the middle of a block.
- `fifo_level`  output  clog2(FIFO_DEPTH)+1  number of bytes held.

## Operation
- Bit order is LSB-first. The first sampled bit of a block becomes bit 0 of byte 0, and byte 0 leaves the FIFO first. The shift register loads as {ser_in, sr[7:1]}.
- The bit counter `bcnt` ranges over 0..BLOCK_BITS-1. It increments on each sampled bit and wraps to 0 after BLOCK_BITS-1.
- On the 8th bit of a byte (bcnt[2:0]==7), the completed byte, {ser_in, sr[7:1]}, is pushed on the same edge.
- On the edge where bcnt==BLOCK_BITS-1 is sampled, `block_done` is registered high for exactly one cycle.
- Truncation: if `ser_valid`=0 while bcnt≠0:
  - the partial byte is discarded;
  - bcnt is cleared to 0;
  - `frame_err` is set.
  - Bytes already pushed from that block remain in the FIFO.
- `ser_valid`=0 with bcnt==0 is idle and causes no action.
- Overflow: a push while the FIFO is full and no pop occurs on the same edge drops the new byte, sets `overflow` and leaves FIFO contents unchanged.
- Simultaneous push and pop:
  - When the FIFO is full, the push is accepted and the level is unchanged.
  - When the FIFO is empty, no pop is possible. The push lands and `byte_valid` rises on the next cycle.
- If an error event and `err_clr` occur on the same edge, the flag ends up set (set wins).
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_level`.
- Reset values:
  - `byte_valid`=0, `block_done`=0, `overflow`=0, `frame_err`=0, `fifo_level`=0.
  - bcnt=0, shift register=0, FIFO pointers=0.
  - `byte_out` reads as 0x00: storage is cleared on reset.
- Reset asserted mid-block or with the FIFO non-empty discards everything, including the partial byte and all buffered bytes. The first bit sampled after reset is bit 0 of a new block.

## Timing
- Latency: a byte completed by a sample at edge N is visible on `byte_out`/`byte_valid` in the cycle after edge N. This holds when the FIFO was empty, since the FIFO is first-word fall-through.
- `block_done` is high in the same cycle in which the last byte of the block first becomes visible.
- `byte_out` changes only on a pop or on the push into an empty FIFO. It is stable while `byte_valid`=1 and `byte_ready`=0.
- Throughput: one bit per cycle in, one byte per cycle out. No input backpressure exists; loss is reported through `overflow`.
- `fifo_level` is registered and updates on the edge of each push or pop.
- All outputs are registered or driven directly from FIFO storage. There is no combinational path from `byte_ready` to `byte_valid`.

## Test plan
- Reset, then stream 64 bits of 0x0123456789ABCDEF LSB-first with `byte_ready`=1.
  - Required: bytes EF, CD, AB, 89, 67, 45, 23, 01 emerge in that order.
  - Required: `block_done` pulses once, coincident with 0x01 becoming visible.
- Hold `byte_ready`=0 and stream 2 blocks with FIFO_DEPTH=4.
  - Required: `fifo_level` saturates at 4 and `overflow`=1.
  - Required: draining yields exactly the first 4 bytes of block 1.
- Drop `ser_valid` after 20 bits.
  - Required: 2 bytes are delivered and `frame_err`=1.
  - Required: the next 64-bit block is delivered intact with a correct `block_done`.
- With the FIFO full, push and pop on the same edge.
  - Required: level stays 4, no overflow, and the byte order is preserved.
- Assert `reset` mid-block with 3 bytes buffered.
  - Required: next cycle `byte_valid`=0, `fifo_level`=0 and all flags are 0.
  - Required: the following stream is framed from bit 0.
- Pulse `err_clr` together with a new overflow event.
  - Required: `overflow` remains 1.
  - Required: a second `err_clr` with no event clears it.

Source files
------------

// File: rtl/simon_stream_collector.sv
// simon_stream_collector
// Packs the Simon core's LSB-first serial stream into bytes, buffers them in a
// small first-word-fall-through FIFO and presents them on a valid/ready byte
// port. Also flags block completion, truncated blocks and dropped bytes.
module simon_stream_collector #(
  parameter int BLOCK_BITS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  input  logic                         err_clr,
  output logic [7:0]                   byte_out,
  output logic                         byte_valid,
  input  logic                         byte_ready,
  output logic                         block_done,
  output logic                         overflow,
  output logic                         frame_err,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (BLOCK_BITS > 8) ? $clog2(BLOCK_BITS) : 3;

  localparam logic [CW-1:0] BCNT_LAST = CW'(BLOCK_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  // Bit counter within the block and the bits of the current byte received
  // so far (newest bit at the top; equivalent to sr[7:1] of an 8-bit shifter).
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [6:0]    sr_q, sr_d;

  // FIFO storage and bookkeeping.
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          valid_q, valid_d;

  // Status outputs.
  logic          block_done_q, block_done_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;

  // Per-edge events.
  logic          byte_end_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          push_ok_s;
  logic          ovf_evt_s;
  logic          trunc_evt_s;
  logic [7:0]    new_byte_s;

  // Deframing: bit counter, shift register, truncation and block-end detection.
  always_comb begin
    byte_end_s   = (bcnt_q[2:0] == 3'd7);
    new_byte_s   = {ser_in, sr_q};
    push_s       = 1'b0;
    trunc_evt_s  = 1'b0;
    block_done_d = 1'b0;
    bcnt_d       = bcnt_q;
    sr_d         = sr_q;
    if (ser_valid) begin
      push_s       = byte_end_s;
      sr_d         = {ser_in, sr_q[6:1]};
      block_done_d = (bcnt_q == BCNT_LAST);
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d = '0;
      end else begin
        bcnt_d = bcnt_q + CW'(1);
      end
    end else if (bcnt_q != '0) begin
      // Stream stopped mid-block: drop the partial byte and reframe.
      trunc_evt_s = 1'b1;
      bcnt_d      = '0;
      sr_d        = '0;
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // FIFO control: a pop on a full FIFO frees the slot the same-edge push uses.
  always_comb begin
    full_s    = (level_q == LVL_FULL);
    pop_s     = valid_q && byte_ready;
    push_ok_s = push_s && (!full_s || pop_s);
    ovf_evt_s = push_s && full_s && !pop_s;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = new_byte_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);
  end

  // Sticky error flags; a new event on the same edge as err_clr keeps the flag set.
  always_comb begin
    if (ovf_evt_s) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    if (trunc_evt_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
  end

  // State register; reset clears storage too so byte_out reads 0x00.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q       <= '0;
      sr_q         <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      valid_q      <= 1'b0;
      block_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      bcnt_q       <= bcnt_d;
      sr_q         <= sr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      valid_q      <= valid_d;
      block_done_q <= block_done_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign byte_out   = mem_q[rd_ptr_q];
  assign byte_valid = valid_q;
  assign block_done = block_done_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_simon_stream_collector.sv
// Self-checking bench for simon_stream_collector: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_simon_stream_collector;

  localparam int BB    = 64;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       block_done;
  logic       overflow;
  logic       frame_err;
  logic [2:0] fifo_level;

  simon_stream_collector #(.BLOCK_BITS(BB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ser_in(ser_in), .ser_valid(ser_valid),
    .err_clr(err_clr), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .block_done(block_done), .overflow(overflow),
    .frame_err(frame_err), .fifo_level(fifo_level)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit         model_on = 1'b0;
  int         m_bits = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_q[$];
  logic       m_done = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_ferr = 1'b0;

  task automatic model_step();
    bit pop, push, ovf_e, fe;
    logic [7:0] nb;
    if (reset) begin
      model_on = 1'b1;
      m_bits = 0; m_acc = 8'h00; m_q.delete();
      m_done = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
    end else if (model_on) begin
      pop = (m_q.size() > 0) && byte_ready;
      push = 1'b0; ovf_e = 1'b0; fe = 1'b0; nb = 8'h00;
      m_done = 1'b0;
      if (ser_valid) begin
        m_acc[m_bits % 8] = ser_in;
        if (m_bits % 8 == 7) begin
          push = 1'b1; nb = m_acc; m_acc = 8'h00;
        end
        if (m_bits == BB - 1) m_done = 1'b1;
        m_bits = (m_bits + 1) % BB;
      end else if (m_bits != 0) begin
        fe = 1'b1; m_bits = 0; m_acc = 8'h00;
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(nb);
        else ovf_e = 1'b1;
      end
      m_ovf  = ovf_e ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_ferr = fe    ? 1'b1 : (err_clr ? 1'b0 : m_ferr);
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model.
  task automatic cyc(input logic r, input logic v, input logic b, input logic rdy, input logic clr);
    reset = r; ser_valid = v; ser_in = b; byte_ready = rdy; err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_bits(input logic [63:0] data, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, data[i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // ---------------- per-cycle compare and pop log ----------------
  logic [7:0] dut_out[$];
  int         done_cnt = 0;
  logic [7:0] last_done_byte = 8'h00;

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      check("byte_valid", {31'd0, byte_valid}, {31'd0, (m_q.size() > 0)});
      check("fifo_level", {29'd0, fifo_level}, 32'(m_q.size()));
      check("block_done", {31'd0, block_done}, {31'd0, m_done});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      if (m_q.size() > 0) check("byte_out", {24'd0, byte_out}, {24'd0, m_q[0]});
      if (block_done) begin
        done_cnt++;
        last_done_byte = byte_out;
      end
      if (!reset && byte_valid && byte_ready) dut_out.push_back(byte_out);
    end
  end

  task automatic check_bytes(input string nm, input logic [63:0] data, input int first, input int n);
    check({nm, "_count"}, 32'(dut_out.size()), 32'(n));
    for (int k = 0; k < n && k < dut_out.size(); k++)
      check(nm, {24'd0, dut_out[k]}, {24'd0, data[8*(first+k) +: 8]});
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [63:0] d;
    logic [7:0]  exp1 [8];
    int          d0;
    exp1[0] = 8'hEF; exp1[1] = 8'hCD; exp1[2] = 8'hAB; exp1[3] = 8'h89;
    exp1[4] = 8'h67; exp1[5] = 8'h45; exp1[6] = 8'h23; exp1[7] = 8'h01;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_byte_out", {24'd0, byte_out}, 32'h00);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);

    // Known block, consumer always ready.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    d = 64'h0123456789ABCDEF;
    send_bits(d, 64, 1'b1);
    idle(4, 1'b1);
    check("t1_count", 32'(dut_out.size()), 32'd8);
    for (int k = 0; k < 8 && k < dut_out.size(); k++)
      check("t1_byte", {24'd0, dut_out[k]}, {24'd0, exp1[k]});
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_done_byte", {24'd0, last_done_byte}, 32'h01);

    // Two blocks with no consumer: saturate and overflow.
    dut_out.delete();
    d = {$urandom, $urandom};
    send_bits(d, 64, 1'b0);
    send_bits({$urandom, $urandom}, 64, 1'b0);
    check("t2_level", {29'd0, fifo_level}, 32'd4);
    check("t2_overflow", {31'd0, overflow}, 32'd1);
    idle(8, 1'b1);
    check_bytes("t2_byte", d, 0, 4);

    // Truncated block after 20 bits, then an intact block.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    dut_out.delete();
    d = {$urandom, $urandom};
    send_bits(d, 20, 1'b1);
    idle(4, 1'b1);
    check_bytes("t3_trunc", d, 0, 2);
    check("t3_frame_err", {31'd0, frame_err}, 32'd1);
    dut_out.delete();
    d0 = done_cnt;
    d = {$urandom, $urandom};
    send_bits(d, 64, 1'b1);
    idle(4, 1'b1);
    check_bytes("t3_block", d, 0, 8);
    check("t3_done_cnt", 32'(done_cnt), 32'(d0 + 1));

    // Push and pop on the same edge while full.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    dut_out.delete();
    d = {$urandom, $urandom};
    send_bits(d, 32, 1'b0);
    check("t4_full", {29'd0, fifo_level}, 32'd4);
    for (int i = 32; i < 40; i++) cyc(1'b0, 1'b1, d[i], (i == 39), 1'b0);
    check("t4_level", {29'd0, fifo_level}, 32'd4);
    check("t4_overflow", {31'd0, overflow}, 32'd0);
    idle(8, 1'b1);
    check_bytes("t4_byte", d, 0, 5);

    // Reset mid-block with 3 bytes buffered.
    dut_out.delete();
    send_bits({$urandom, $urandom}, 28, 1'b0);
    check("t5_pre_level", {29'd0, fifo_level}, 32'd3);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_valid", {31'd0, byte_valid}, 32'd0);
    check("t5_level", {29'd0, fifo_level}, 32'd0);
    check("t5_flags", {29'd0, overflow, frame_err, block_done}, 32'd0);
    check("t5_byte_out", {24'd0, byte_out}, 32'h00);
    d = {$urandom, $urandom};
    send_bits(d, 64, 1'b1);
    idle(4, 1'b1);
    check_bytes("t5_byte", d, 0, 8);

    // Overflow on the same edge as err_clr, then a clean err_clr.
    d = {$urandom, $urandom};
    send_bits(d, 32, 1'b0);
    for (int i = 32; i < 40; i++) cyc(1'b0, 1'b1, d[i], 1'b0, (i == 39));
    check("t6_ovf_set_wins", {31'd0, overflow}, 32'd1);
    cyc(1'b0, 1'b1, d[40], 1'b0, 1'b1);
    check("t6_ovf_cleared", {31'd0, overflow}, 32'd0);
    idle(8, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 31) != 0),
          1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    idle(8, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
